// File: rtl/vector_sequencing_control_unit.sv
// Registered instruction decoder and memory-beat sequencer: holds the control word across multi-beat transfers.
// Optional build macro CU_PERF_COUNTERS_EN adds retired_cnt / stall_cnt saturating counters.
module vector_sequencing_control_unit #(
  parameter int LANES = 8,
  parameter int MEM_PORTS = 2,
  localparam int BEATS = LANES / MEM_PORTS,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instruction_type,
  input  logic [1:0]        func,
  input  logic              imm,
  input  logic              vector,
  input  logic              mem_ready,
  output logic              ctrl_valid,
  output logic              JumpI,
  output logic              JumpCI,
  output logic              JumpCD,
  output logic              MemToReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              ImmSrc,
  output logic              VectorOp,
  output logic              ALUSrc1,
  output logic              ALUSrc3,
  output logic              RegVWrite,
  output logic              RegSWrite,
  output logic              Loading,
  output logic [1:0]        ALUOp,
  output logic [1:0]        ALUSrc2,
  output logic [BEAT_W-1:0] beat_idx,
`ifdef CU_PERF_COUNTERS_EN
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MEM  = 2'd2;

  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src3;
    logic       reg_v_write;
    logic       reg_s_write;
    logic       loading;
    logic [1:0] alu_op;
    logic [1:0] alu_src2;
  } ctrl_t;

  logic [1:0]        state;
  ctrl_t             word;
  ctrl_t             dec;
  logic              dec_legal;
  logic              dec_mem;
  logic [BEAT_W-1:0] last_idx;
  logic              accept;
  logic              done;

  // Handshake: fields transfer on a cycle where instr_valid & instr_ready;
  // ready also rises on the final accepted memory beat so issue is back-to-back.
  assign done        = (state == MEM) && mem_ready && (beat_idx == last_idx);
  assign instr_ready = (state != MEM) || ((beat_idx == last_idx) && mem_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    dec_mem   = 1'b0;
    case (instruction_type)
      2'b00: begin
        case ({func, imm})
          3'b000: begin dec_legal = 1'b1; dec.jump_ci = 1'b1; dec.imm_src = 1'b1; dec.alu_src2 = 2'b11; end
          3'b001: begin dec_legal = 1'b1; dec.jump_i = 1'b1; end
          3'b010: begin dec_legal = 1'b1; dec.jump_cd = 1'b1; dec.imm_src = 1'b1; dec.alu_src2 = 2'b11; end
          default: ;
        endcase
      end
      2'b01: begin
        if (!func[1]) begin
          dec_legal    = 1'b1;
          dec_mem      = 1'b1;
          dec.imm_src  = 1'b1;
          dec.alu_src2 = 2'b10;
          if (func[0]) begin
            dec.mem_read    = 1'b1;
            dec.mem_to_reg  = 1'b1;
            dec.reg_v_write = vector;
            dec.reg_s_write = !vector;
          end else begin
            dec.mem_write = 1'b1;
            dec.alu_src1  = vector;
          end
          dec.vector_op = vector;
          dec.loading   = vector && func[0];
        end
      end
      2'b10: begin
        if (imm) begin
          dec_legal       = 1'b1;
          dec.alu_src2    = 2'b10;
          dec.imm_src     = 1'b1;
          dec.reg_s_write = 1'b1;
          dec.alu_op      = func;
        end else if (vector && func != 2'b11) begin
          dec_legal       = 1'b1;
          dec.alu_src3    = 1'b1;
          dec.alu_op      = func;
          dec.reg_v_write = 1'b1;
          dec.vector_op   = 1'b1;
        end else if (!vector && !func[1]) begin
          dec_legal       = 1'b1;
          dec.alu_src2    = 2'b01;
          dec.alu_op      = func;
          dec.reg_s_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      ctrl_valid <= 1'b0;
      beat_idx   <= '0;
      last_idx   <= '0;
      illegal    <= 1'b0;
    end else if (accept) begin
      beat_idx <= '0;
      if (!dec_legal) begin
        // Illegal instructions take an EXEC slot as a bubble with no live controls.
        state      <= EXEC;
        word       <= '0;
        ctrl_valid <= 1'b0;
        illegal    <= 1'b1;
      end else begin
        state      <= dec_mem ? MEM : EXEC;
        word       <= dec;
        ctrl_valid <= 1'b1;
        illegal    <= 1'b0;
        last_idx   <= (dec_mem && vector) ? BEAT_W'(BEATS - 1) : '0;
      end
    end else if (state == MEM && !done) begin
      illegal <= 1'b0;
      if (mem_ready) beat_idx <= beat_idx + BEAT_W'(1);
    end else begin
      state      <= IDLE;
      word       <= '0;
      ctrl_valid <= 1'b0;
      beat_idx   <= '0;
      illegal    <= 1'b0;
    end
  end

`ifdef CU_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (((state == EXEC && ctrl_valid) || done) && retired_cnt != 32'hFFFF_FFFF)
        retired_cnt <= retired_cnt + 32'd1;
      if (instr_valid && !instr_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign JumpI     = word.jump_i;
  assign JumpCI    = word.jump_ci;
  assign JumpCD    = word.jump_cd;
  assign MemToReg  = word.mem_to_reg;
  assign MemRead   = word.mem_read;
  assign MemWrite  = word.mem_write;
  assign ImmSrc    = word.imm_src;
  assign VectorOp  = word.vector_op;
  assign ALUSrc1   = word.alu_src1;
  assign ALUSrc3   = word.alu_src3;
  assign RegVWrite = word.reg_v_write;
  assign RegSWrite = word.reg_s_write;
  assign Loading   = word.loading;
  assign ALUOp     = word.alu_op;
  assign ALUSrc2   = word.alu_src2;

endmodule

// File: tb/tb_vector_sequencing_control_unit.sv
// Directed bench for vector_sequencing_control_unit: expected output words are queued as stimulus is driven.
module tb_vector_sequencing_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instruction_type;
  logic [1:0] func;
  logic       imm;
  logic       vector;
  logic       mem_ready;
  logic       ctrl_valid;
  logic       JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ImmSrc;
  logic       VectorOp, ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, Loading;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrc2;
  logic [1:0] beat_idx;
  logic       illegal;
`ifdef CU_PERF_COUNTERS_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [20:0] exp_q[$];
  logic [20:0] obs;

  localparam logic [12:0] F_JI  = 13'h1000;
  localparam logic [12:0] F_JCI = 13'h0800;
  localparam logic [12:0] F_JCD = 13'h0400;
  localparam logic [12:0] F_M2R = 13'h0200;
  localparam logic [12:0] F_MRD = 13'h0100;
  localparam logic [12:0] F_MW  = 13'h0080;
  localparam logic [12:0] F_IMM = 13'h0040;
  localparam logic [12:0] F_VOP = 13'h0020;
  localparam logic [12:0] F_A1  = 13'h0010;
  localparam logic [12:0] F_A3  = 13'h0008;
  localparam logic [12:0] F_RVW = 13'h0004;
  localparam logic [12:0] F_RSW = 13'h0002;
  localparam logic [12:0] F_LD  = 13'h0001;
  localparam logic [20:0] ZERO  = 21'h0;

  localparam logic [12:0] VL = F_MRD | F_M2R | F_RVW | F_VOP | F_LD | F_IMM;
  localparam logic [12:0] VS = F_MW | F_A1 | F_VOP | F_IMM;

  logic       mr_pat[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] nb_pat[5]  = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};

  vector_sequencing_control_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction_type(instruction_type), .func(func), .imm(imm), .vector(vector),
    .mem_ready(mem_ready), .ctrl_valid(ctrl_valid),
    .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .ImmSrc(ImmSrc), .VectorOp(VectorOp),
    .ALUSrc1(ALUSrc1), .ALUSrc3(ALUSrc3), .RegVWrite(RegVWrite), .RegSWrite(RegSWrite),
    .Loading(Loading), .ALUOp(ALUOp), .ALUSrc2(ALUSrc2), .beat_idx(beat_idx),
`ifdef CU_PERF_COUNTERS_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .illegal(illegal)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  assign obs = {ctrl_valid, illegal, beat_idx, JumpI, JumpCI, JumpCD, MemToReg, MemRead,
                MemWrite, ImmSrc, VectorOp, ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, Loading,
                ALUOp, ALUSrc2};

  function automatic logic [20:0] w(input logic cv, input logic il, input logic [1:0] bi,
                                    input logic [12:0] f, input logic [1:0] aop,
                                    input logic [1:0] as2);
    return {cv, il, bi, f, aop, as2};
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [1:0] t, input logic [1:0] f,
                       input logic i, input logic vec);
    instr_valid      = v;
    instruction_type = t;
    func             = f;
    imm              = i;
    vector           = vec;
  endtask

  task automatic expect_next(input logic [20:0] e);
    exp_q.push_back(e);
  endtask

  // Scoreboard: one queued word per clock, compared just after the edge
  task automatic tick_check(input string tag);
    logic [20:0] e;
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h but expectation queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_ready(input logic e, input string tag);
    #1;
    n_cmp++;
    assert (instr_ready === e) else begin
      n_bad++;
      $error("FAIL %s: instr_ready got %b expected %b", tag, instr_ready, e);
    end
  endtask

  task automatic chk_val(input logic [31:0] got, input logic [31:0] e, input string tag);
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    drive(0, 2'b00, 2'b00, 0, 0);
    expect_next(ZERO); tick_check("reset");
    expect_next(ZERO); tick_check("reset_hold");
    rst = 1'b0;
    chk_ready(1'b1, "ready_after_reset");

    // Data imm0 scalar func01: single EXEC cycle; mem_ready outside MEM is ignored
    drive(1, 2'b10, 2'b01, 0, 0);
    mem_ready = 1'($urandom_range(0, 1));
    chk_ready(1'b1, "ready_idle");
    expect_next(w(1, 0, 2'd0, F_RSW, 2'b01, 2'b01)); tick_check("data_scalar");
    drive(0, 2'b00, 2'b00, 0, 0);
    mem_ready = 1'($urandom_range(0, 1));
    expect_next(ZERO); tick_check("data_one_cycle");

    // Vector load, mem_ready pattern 1,0,1,1,1
    drive(1, 2'b01, 2'b01, 0, 1);
    chk_ready(1'b1, "vload_ready_in");
    expect_next(w(1, 0, 2'd0, VL, 2'b00, 2'b10)); tick_check("vload_accept");
    drive(0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_pat[i];
      chk_ready(i == 4, "vload_ready");
      if (i == 4) expect_next(ZERO);
      else expect_next(w(1, 0, nb_pat[i], VL, 2'b00, 2'b10));
      tick_check("vload_beat");
    end

    // Scalar store stalled two cycles, second instruction queued behind it
    drive(1, 2'b01, 2'b00, 0, 0);
    mem_ready = 1'b0;
    chk_ready(1'b1, "sstore_ready_in");
    expect_next(w(1, 0, 2'd0, F_MW | F_IMM, 2'b00, 2'b10)); tick_check("sstore_accept");
    drive(1, 2'b10, 2'b10, 1, 0);
    chk_ready(1'b0, "sstore_stall1");
    expect_next(w(1, 0, 2'd0, F_MW | F_IMM, 2'b00, 2'b10)); tick_check("sstore_hold1");
    chk_ready(1'b0, "sstore_stall2");
    expect_next(w(1, 0, 2'd0, F_MW | F_IMM, 2'b00, 2'b10)); tick_check("sstore_hold2");
    mem_ready = 1'b1;
    chk_ready(1'b1, "sstore_done_ready");
    expect_next(w(1, 0, 2'd0, F_IMM | F_RSW, 2'b10, 2'b10)); tick_check("b2b_accept");
    drive(0, 2'b00, 2'b00, 0, 0);
    expect_next(ZERO); tick_check("b2b_idle");

    // Illegal pulse, then a run of back-to-back legal and illegal decodes
    drive(1, 2'b11, 2'b00, 0, 0);
    mem_ready = 1'($urandom_range(0, 1));
    chk_ready(1'b1, "ready_pre_illegal");
    expect_next(w(0, 1, 2'd0, 13'h0, 2'b00, 2'b00)); tick_check("illegal_pulse");
    drive(1, 2'b00, 2'b00, 1, 0);
    chk_ready(1'b1, "ready_bubble");
    expect_next(w(1, 0, 2'd0, F_JI, 2'b00, 2'b00)); tick_check("jumpi");
    drive(1, 2'b00, 2'b00, 0, 0);
    expect_next(w(1, 0, 2'd0, F_JCI | F_IMM, 2'b00, 2'b11)); tick_check("jumpci");
    drive(1, 2'b00, 2'b01, 0, 0);
    expect_next(w(1, 0, 2'd0, F_JCD | F_IMM, 2'b00, 2'b11)); tick_check("jumpcd");
    drive(1, 2'b10, 2'b10, 0, 1);
    expect_next(w(1, 0, 2'd0, F_A3 | F_RVW | F_VOP, 2'b10, 2'b00)); tick_check("data_vector");
    drive(1, 2'b01, 2'b11, 0, 0);
    expect_next(w(0, 1, 2'd0, 13'h0, 2'b00, 2'b00)); tick_check("illegal_mem");
    drive(1, 2'b10, 2'b11, 0, 0);
    expect_next(w(0, 1, 2'd0, 13'h0, 2'b00, 2'b00)); tick_check("illegal_data");
    drive(1, 2'b00, 2'b11, 1, 0);
    expect_next(w(0, 1, 2'd0, 13'h0, 2'b00, 2'b00)); tick_check("illegal_ctrl");
    drive(0, 2'b00, 2'b00, 0, 0);
    expect_next(ZERO); tick_check("idle_after_illegal");

    // Reset held three cycles in the middle of a vector load
    drive(1, 2'b01, 2'b01, 0, 1);
    expect_next(w(1, 0, 2'd0, VL, 2'b00, 2'b10)); tick_check("vload2_accept");
    drive(0, 2'b00, 2'b00, 0, 0);
    mem_ready = 1'b1;
    expect_next(w(1, 0, 2'd1, VL, 2'b00, 2'b10)); tick_check("vload2_beat");
    rst = 1'b1;
    expect_next(ZERO); tick_check("rst_mid_mem");
    chk_ready(1'b1, "ready_in_rst");
    expect_next(ZERO); tick_check("rst_hold2");
    expect_next(ZERO); tick_check("rst_hold3");
    rst = 1'b0;
    expect_next(ZERO); tick_check("after_rst");
    chk_ready(1'b1, "ready_after_rst");

    // 4-beat vector store with the next instruction held valid behind it
    drive(1, 2'b01, 2'b00, 0, 1);
    mem_ready = 1'b1;
    expect_next(w(1, 0, 2'd0, VS, 2'b00, 2'b10)); tick_check("vstore_accept");
    drive(1, 2'b10, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk_ready(i == 3, "vstore_ready");
      if (i == 3) expect_next(w(1, 0, 2'd0, F_RSW, 2'b00, 2'b01));
      else expect_next(w(1, 0, 2'(i + 1), VS, 2'b00, 2'b10));
      tick_check("vstore_beat");
    end
`ifdef CU_PERF_COUNTERS_EN
    chk_val(stall_cnt, 32'd3, "stall_cnt");
    chk_val(retired_cnt, 32'd1, "retired_cnt");
`endif
    drive(0, 2'b00, 2'b00, 0, 0);
    expect_next(ZERO); tick_check("final_idle");
`ifdef CU_PERF_COUNTERS_EN
    chk_val(stall_cnt, 32'd3, "stall_cnt_final");
    chk_val(retired_cnt, 32'd2, "retired_cnt_final");
`endif

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
